// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide UART transmitter with a valid/ready handshake.
// Frame: 1 start bit, DATA_BITS data bits sent LSB first, optional parity bit,
// and STOP_BITS stop bits. The shared clk_baud tick sets the bit timing.
// Build option UART_TX_PARITY_EN: when defined, an even-parity bit follows
// the data bits.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | line idle (tx=1); the handshake accepts a byte here
// ST_SYNC    | byte latched; wait for a tick so the start bit is a full period
// ST_START   | start bit (tx=0)
// ST_DATA    | data bits; bit_counter is the index of the bit on the line
// ST_PARITY  | even-parity bit (only when UART_TX_PARITY_EN is defined)
// ST_STOP    | stop bits (tx=1); a down-counter tracks the remaining periods
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_baud,
  input  logic                 tx_abort,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [3:0]           bit_counter
);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [1:0] STOP_LOAD = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // State and datapath registers; reset returns the line to idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next state and next line value; abort overrides accept and baud ticks.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (tx_abort) begin
      state_d   = ST_IDLE;
      tx_d      = 1'b1;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_d = 1'b1;
          // A tick arriving with the accept is deliberately ignored.
          if (tx_valid) begin
            shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
            parity_d = ^tx_data;
`endif
            state_d  = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (clk_baud) begin
            state_d = ST_START;
            tx_d    = 1'b0;
          end
        end
        ST_START: begin
          if (clk_baud) begin
            state_d   = ST_DATA;
            tx_d      = shift_q[0];
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          if (clk_baud) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
              state_d    = ST_PARITY;
              tx_d       = parity_q;
`else
              state_d    = ST_STOP;
              tx_d       = 1'b1;
              stop_cnt_d = STOP_LOAD;
`endif
            end else begin
              shift_d   = shift_q >> 1;
              tx_d      = shift_q[1];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (clk_baud) begin
            state_d    = ST_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = STOP_LOAD;
          end
        end
`endif
        ST_STOP: begin
          tx_d = 1'b1;
          if (clk_baud) begin
            if (stop_cnt_q == 2'd0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              stop_cnt_d = stop_cnt_q - 2'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  assign tx          = tx_q;
  assign tx_done     = done_q;
  assign bit_counter = bit_cnt_q;
  assign tx_ready    = (state_q == ST_IDLE);
  assign tx_busy     = (state_q != ST_IDLE);

endmodule
